// File: rtl/cpu_pkg.sv
// Shared constants and state types for the UART program loader.
// Frame header codes, response bytes and FSM encodings live here.
package cpu_pkg;

    localparam logic [7:0] HDR_IMEM = 8'h49;
    localparam logic [7:0] HDR_DMEM = 8'h44;
    localparam logic [7:0] ACK      = 8'h06;
    localparam logic [7:0] NAK      = 8'h15;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        CNT_LO,
        CNT_HI,
        DATA,
        WRITE,
        RESP,
        WAIT_TX
    } upg_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_START,
        R_DATA,
        R_STOP
    } rx_state_t;

    // Counter width for a modulus, never below one bit.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/uart_prog_loader_if.sv
// Memory write port of the program loader.
// The loader drives it; the CPU memories listen.
interface uart_prog_loader_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
);

    logic              upg_wen_o;
    logic [ADDR_W:0]   upg_adr_o;
    logic [DATA_W-1:0] upg_dat_o;
    logic              upg_done_o;

    modport master (
        output upg_wen_o,
        output upg_adr_o,
        output upg_dat_o,
        output upg_done_o
    );

    modport slave (
        input upg_wen_o,
        input upg_adr_o,
        input upg_dat_o,
        input upg_done_o
    );

endinterface

// File: rtl/uart_rx.sv
// 16x oversampled 8N1 receiver with glitch-rejecting start detection.
// Also emits a bit-period tick while the line is idle.
module uart_rx
    import cpu_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       valid_o,
    output logic       ferr_o,
    output logic       tick_o
);

    localparam int DW  = clog2_min1(DIV);
    localparam int BIT = DIV * 16;
    localparam int BW  = clog2_min1(BIT);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(BIT - 1);

    logic          rx_s1_q;
    logic          rx_s2_q;
    logic [BW-1:0] bt_q;
    rx_state_t     rs_q, rs_d;
    logic [DW-1:0] div_q, div_d;
    logic [3:0]    os_q, os_d;
    logic [2:0]    nb_q, nb_d;
    logic [7:0]    sh_q, sh_d;
    logic [7:0]    byte_q, byte_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          os_tick;

    assign os_tick = (div_q == DIV_LAST);
    assign byte_o  = byte_q;
    assign valid_o = valid_q;
    assign ferr_o  = ferr_q;
    assign tick_o  = (bt_q == BIT_LAST) && (rs_q == R_IDLE);

    // Line synchroniser and free-running bit-period counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
            bt_q    <= '0;
        end else begin
            rx_s1_q <= rx_i;
            rx_s2_q <= rx_s1_q;
            bt_q    <= (bt_q == BIT_LAST) ? '0 : bt_q + BW'(1);
        end
    end

    // Receiver state and shift registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rs_q    <= R_IDLE;
            div_q   <= '0;
            os_q    <= '0;
            nb_q    <= '0;
            sh_q    <= '0;
            byte_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            rs_q    <= rs_d;
            div_q   <= div_d;
            os_q    <= os_d;
            nb_q    <= nb_d;
            sh_q    <= sh_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    // Sample start at tick 8, then every 16 ticks for data and stop.
    always_comb begin
        rs_d    = rs_q;
        os_d    = os_q;
        nb_d    = nb_q;
        sh_d    = sh_q;
        byte_d  = byte_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        div_d   = (rs_q == R_IDLE || os_tick) ? '0 : div_q + DW'(1);
        unique case (rs_q)
            R_IDLE: begin
                if (!rx_s2_q) begin
                    rs_d = R_START;
                    os_d = '0;
                end
            end
            R_START: begin
                if (os_tick) begin
                    if (os_q == 4'd7) begin
                        os_d = '0;
                        nb_d = '0;
                        rs_d = rx_s2_q ? R_IDLE : R_DATA;
                    end else begin
                        os_d = os_q + 4'd1;
                    end
                end
            end
            R_DATA: begin
                if (os_tick) begin
                    os_d = os_q + 4'd1;
                    if (os_q == 4'd15) begin
                        sh_d = {rx_s2_q, sh_q[7:1]};
                        nb_d = nb_q + 3'd1;
                        if (nb_q == 3'd7) begin
                            rs_d = R_STOP;
                        end
                    end
                end
            end
            R_STOP: begin
                if (os_tick) begin
                    os_d = os_q + 4'd1;
                    if (os_q == 4'd15) begin
                        rs_d    = R_IDLE;
                        byte_d  = sh_q;
                        valid_d = rx_s2_q;
                        ferr_d  = !rx_s2_q;
                    end
                end
            end
        endcase
    end

endmodule

// File: rtl/uart_prog_loader.sv
// UART programmer: receives a framed image and writes it into
// program ROM or data memory, then answers with ACK or NAK.
module uart_prog_loader
    import cpu_pkg::*;
#(
    parameter int CLK_HZ       = 23_000_000,
    parameter int BAUD         = 115_200,
    parameter int ADDR_W       = 14,
    parameter int DATA_W       = 32,
    parameter int TIMEOUT_BITS = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_pg,
    input  logic                 rx,
    output logic                 tx,
    output logic                 busy_o,
    uart_prog_loader_if.master   upg
);

    localparam int DIV  = CLK_HZ / (BAUD * 16);
    localparam int BIT  = DIV * 16;
    localparam int BW   = clog2_min1(BIT);
    localparam int NB   = DATA_W / 8;
    localparam int BC_W = clog2_min1(NB);
    localparam int TO_W = clog2_min1(TIMEOUT_BITS);
    localparam logic [BW-1:0]   BIT_LAST = BW'(BIT - 1);
    localparam logic [BC_W-1:0] BC_LAST  = BC_W'(NB - 1);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_BITS - 1);
    localparam int unsigned     MAX_N    = 32'd1 << ADDR_W;

    logic [7:0]        rx_byte;
    logic              rx_valid;
    logic              rx_ferr;
    logic              rx_tick;

    logic [2:0]        sp_q;
    logic              sp_rise;

    upg_state_t        state_q, state_d;
    logic              sel_q, sel_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [15:0]       idx_q, idx_d;
    logic [BC_W-1:0]   bcnt_q, bcnt_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic [7:0]        resp_q, resp_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic              done_q, done_d;
    logic              wen_q, wen_d;
    logic [ADDR_W:0]   adr_q, adr_d;
    logic [DATA_W-1:0] dat_q, dat_d;

    logic              tx_q;
    logic [8:0]        tx_sh_q;
    logic [3:0]        tx_bits_q;
    logic [BW-1:0]     tx_cnt_q;
    logic              tx_load;
    logic              tx_busy;

    logic [15:0]       n_cnt;
    logic              tmo;

    uart_rx #(
        .DIV (DIV)
    ) u_rx (
        .clk     (clk),
        .rst     (rst),
        .rx_i    (rx),
        .byte_o  (rx_byte),
        .valid_o (rx_valid),
        .ferr_o  (rx_ferr),
        .tick_o  (rx_tick)
    );

    assign sp_rise = sp_q[1] & ~sp_q[2];
    assign n_cnt   = {rx_byte, cnt_q[7:0]};
    assign tmo     = rx_tick && (to_q == TO_LAST);
    assign tx_busy = (tx_bits_q != 4'd0);

    assign tx             = tx_q;
    assign busy_o         = (state_q != IDLE);
    assign upg.upg_wen_o  = wen_q;
    assign upg.upg_adr_o  = adr_q;
    assign upg.upg_dat_o  = dat_q;
    assign upg.upg_done_o = done_q;

    // Two-flop synchroniser plus edge-detect stage for start_pg.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp_q <= '0;
        end else begin
            sp_q <= {sp_q[1:0], start_pg};
        end
    end

    // Loader state, word assembler, address counter and write port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            cnt_q   <= '0;
            idx_q   <= '0;
            bcnt_q  <= '0;
            word_q  <= '0;
            resp_q  <= ACK;
            to_q    <= '0;
            done_q  <= 1'b1;
            wen_q   <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            bcnt_q  <= bcnt_d;
            word_q  <= word_d;
            resp_q  <= resp_d;
            to_q    <= to_d;
            done_q  <= done_d;
            wen_q   <= wen_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
        end
    end

    // Frame parser: header, count, payload, then a response byte.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        bcnt_d  = bcnt_q;
        word_d  = word_q;
        resp_d  = resp_q;
        done_d  = done_q;
        wen_d   = 1'b0;
        adr_d   = adr_q;
        dat_d   = dat_q;
        tx_load = 1'b0;
        to_d    = to_q;
        if (rx_valid || state_q inside {IDLE, HDR, RESP, WAIT_TX}) begin
            to_d = '0;
        end else if (rx_tick) begin
            to_d = to_q + TO_W'(1);
        end
        unique case (state_q)
            IDLE: begin
                if (sp_rise) begin
                    done_d  = 1'b0;
                    state_d = HDR;
                end
            end
            HDR: begin
                if (rx_ferr) begin
                    resp_d  = NAK;
                    state_d = RESP;
                end else if (rx_valid) begin
                    if (rx_byte == HDR_IMEM) begin
                        sel_d   = 1'b0;
                        state_d = CNT_LO;
                    end else if (rx_byte == HDR_DMEM) begin
                        sel_d   = 1'b1;
                        state_d = CNT_LO;
                    end else begin
                        resp_d  = NAK;
                        state_d = RESP;
                    end
                end
            end
            CNT_LO: begin
                if (rx_ferr || (!rx_valid && tmo)) begin
                    resp_d  = NAK;
                    state_d = RESP;
                end else if (rx_valid) begin
                    cnt_d[7:0] = rx_byte;
                    state_d    = CNT_HI;
                end
            end
            CNT_HI: begin
                if (rx_ferr || (!rx_valid && tmo)) begin
                    resp_d  = NAK;
                    state_d = RESP;
                end else if (rx_valid) begin
                    cnt_d   = n_cnt;
                    idx_d   = '0;
                    bcnt_d  = '0;
                    if (n_cnt == 16'd0) begin
                        resp_d  = ACK;
                        state_d = RESP;
                    end else if ({16'd0, n_cnt} > MAX_N) begin
                        resp_d  = NAK;
                        state_d = RESP;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (rx_ferr || (!rx_valid && tmo)) begin
                    resp_d  = NAK;
                    state_d = RESP;
                end else if (rx_valid) begin
                    word_d = (word_q >> 8)
                           | (DATA_W'(rx_byte) << (DATA_W - 8));
                    if (bcnt_q == BC_LAST) begin
                        bcnt_d  = '0;
                        state_d = WRITE;
                    end else begin
                        bcnt_d = bcnt_q + BC_W'(1);
                    end
                end
            end
            WRITE: begin
                wen_d = 1'b1;
                adr_d = {sel_q, idx_q[ADDR_W-1:0]};
                dat_d = word_q;
                idx_d = idx_q + 16'd1;
                if (idx_q + 16'd1 == cnt_q) begin
                    resp_d  = ACK;
                    state_d = RESP;
                end else begin
                    state_d = DATA;
                end
            end
            RESP: begin
                tx_load = 1'b1;
                state_d = WAIT_TX;
            end
            WAIT_TX: begin
                if (!tx_busy) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
        endcase
    end

    // 8N1 transmitter; the bit counter hits zero after the stop bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_q      <= 1'b1;
            tx_sh_q   <= '1;
            tx_bits_q <= '0;
            tx_cnt_q  <= '0;
        end else if (tx_load) begin
            tx_q      <= 1'b0;
            tx_sh_q   <= {1'b1, resp_q};
            tx_bits_q <= 4'd10;
            tx_cnt_q  <= '0;
        end else if (tx_busy) begin
            if (tx_cnt_q == BIT_LAST) begin
                tx_cnt_q  <= '0;
                tx_q      <= tx_sh_q[0];
                tx_sh_q   <= {1'b1, tx_sh_q[8:1]};
                tx_bits_q <= tx_bits_q - 4'd1;
            end else begin
                tx_cnt_q <= tx_cnt_q + BW'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Scoreboard bench for the UART program loader: frames over rx,
// write strobes and tx response bytes checked against queues.
module tb_uart_prog_loader;

    localparam int CLK_HZ = 3_686_400;
    localparam int BAUD   = 115_200;
    localparam int AW     = 4;
    localparam int DW     = 32;
    localparam int TOB    = 16;
    localparam int BIT    = (CLK_HZ / (BAUD * 16)) * 16;
    localparam logic [7:0] B_ACK = 8'h06;
    localparam logic [7:0] B_NAK = 8'h15;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start_pg = 1'b0;
    logic rx = 1'b1;
    logic tx;
    logic busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [AW:0]   exp_adr[$];
    logic [DW-1:0] exp_dat[$];
    logic [7:0]    exp_resp[$];

    always #5 clk = ~clk;

    uart_prog_loader_if #(.ADDR_W(AW), .DATA_W(DW)) upg_if ();

    uart_prog_loader #(
        .CLK_HZ       (CLK_HZ),
        .BAUD         (BAUD),
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .TIMEOUT_BITS (TOB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start_pg (start_pg),
        .rx       (rx),
        .tx       (tx),
        .busy_o   (busy),
        .upg      (upg_if)
    );

    // Write-port scoreboard
    always @(negedge clk) begin
        if (upg_if.upg_wen_o === 1'b1) begin
            n_checks++;
            if (exp_adr.size() == 0) begin
                n_fail++;
                $display("FAIL wr_unexpected: adr=%h dat=%h, required no write",
                         upg_if.upg_adr_o, upg_if.upg_dat_o);
            end else begin
                logic [AW:0]   ea;
                logic [DW-1:0] ed;
                ea = exp_adr.pop_front();
                ed = exp_dat.pop_front();
                if (upg_if.upg_adr_o !== ea || upg_if.upg_dat_o !== ed) begin
                    n_fail++;
                    $display("FAIL wr_data: adr=%h dat=%h, required adr=%h dat=%h",
                             upg_if.upg_adr_o, upg_if.upg_dat_o, ea, ed);
                end
            end
        end
    end

    // tx decoder and response scoreboard
    always begin
        logic [7:0] b;
        logic [7:0] e;
        @(negedge tx);
        repeat (BIT / 2) @(negedge clk);
        if (tx == 1'b0) begin
            for (int i = 0; i < 8; i++) begin
                repeat (BIT) @(negedge clk);
                b[i] = tx;
            end
            repeat (BIT) @(negedge clk);
            n_checks++;
            if (exp_resp.size() == 0) begin
                n_fail++;
                $display("FAIL resp_unexpected: got %h, required none", b);
            end else begin
                e = exp_resp.pop_front();
                if (b !== e || tx !== 1'b1) begin
                    n_fail++;
                    $display("FAIL resp_byte: got %h stop=%b, required %h stop=1",
                             b, tx, e);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        tick(BIT);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(BIT);
        end
        rx = stop_bit;
        tick(BIT);
        rx = 1'b1;
        if (!stop_bit) tick(BIT);
    endtask

    task automatic send_word(input logic [DW-1:0] w);
        for (int i = 0; i < DW / 8; i++) send_byte(w[8*i +: 8], 1'b1);
    endtask

    task automatic pulse_start();
        start_pg = 1'b1;
        tick(4);
        start_pg = 1'b0;
        tick(2);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while ((busy !== 1'b0 || upg_if.upg_done_o !== 1'b1) && n < budget) begin
            tick(1);
            n++;
        end
        n_checks++;
        if (n >= budget) begin
            n_fail++;
            $display("FAIL %s_idle: busy=%b done=%b after %0d cycles, required busy=0 done=1",
                     name, busy, upg_if.upg_done_o, n);
        end
    endtask

    task automatic check_drained(input string name);
        n_checks++;
        if (exp_adr.size() != 0 || exp_resp.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drained: writes left=%0d resp left=%0d, required 0 and 0",
                     name, exp_adr.size(), exp_resp.size());
        end
        exp_adr.delete();
        exp_dat.delete();
        exp_resp.delete();
    endtask

    task automatic check_reset_outputs(input string name);
        n_checks++;
        if (tx !== 1'b1 || upg_if.upg_wen_o !== 1'b0 ||
            upg_if.upg_adr_o !== '0 || upg_if.upg_dat_o !== '0 ||
            upg_if.upg_done_o !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: tx=%b wen=%b adr=%h dat=%h done=%b busy=%b, required 1 0 0 0 1 0",
                     name, tx, upg_if.upg_wen_o, upg_if.upg_adr_o,
                     upg_if.upg_dat_o, upg_if.upg_done_o, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick(3);
        check_reset_outputs("reset_state");
        rst = 1'b1;
        tick(3);
        check_reset_outputs("after_reset");
    endtask

    task automatic test_rom_image();
        logic [7:0] seq [11];
        seq = '{8'h49, 8'h02, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE,
                8'h78, 8'h56, 8'h34, 8'h12};
        exp_adr.push_back('0);
        exp_dat.push_back(32'hDEADBEEF);
        exp_adr.push_back({1'b0, AW'(1)});
        exp_dat.push_back(32'h12345678);
        exp_resp.push_back(B_ACK);
        start_pg = 1'b1;
        tick(2);
        n_checks++;
        if (busy !== 1'b0 || upg_if.upg_done_o !== 1'b1) begin
            n_fail++;
            $display("FAIL start_early: busy=%b done=%b, required 0 1",
                     busy, upg_if.upg_done_o);
        end
        tick(1);
        n_checks++;
        if (busy !== 1'b1 || upg_if.upg_done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL start_latency: busy=%b done=%b, required 1 0",
                     busy, upg_if.upg_done_o);
        end
        tick(2);
        start_pg = 1'b0;
        tick(2);
        for (int i = 0; i < 11; i++) send_byte(seq[i], 1'b1);
        wait_idle("rom", 20 * BIT);
        check_drained("rom");
        n_checks++;
        if (upg_if.upg_adr_o !== {1'b0, AW'(1)} ||
            upg_if.upg_dat_o !== 32'h12345678) begin
            n_fail++;
            $display("FAIL rom_hold: adr=%h dat=%h, required 01 12345678",
                     upg_if.upg_adr_o, upg_if.upg_dat_o);
        end
    endtask

    task automatic test_dmem_select();
        exp_adr.push_back({1'b1, {AW{1'b0}}});
        exp_dat.push_back(32'h00000001);
        exp_resp.push_back(B_ACK);
        pulse_start();
        send_byte(8'h44, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_word(32'h00000001);
        wait_idle("dmem", 20 * BIT);
        check_drained("dmem");
    endtask

    task automatic test_bad_header();
        exp_resp.push_back(B_NAK);
        pulse_start();
        send_byte(8'h00, 1'b1);
        wait_idle("badhdr", 20 * BIT);
        check_drained("badhdr");
    endtask

    task automatic test_oversize();
        logic [DW-1:0] w;
        exp_resp.push_back(B_NAK);
        pulse_start();
        send_byte(8'h49, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h00, 1'b1);
        wait_idle("n17", 20 * BIT);
        check_drained("n17");
        pulse_start();
        send_byte(8'h49, 1'b1);
        send_byte(8'h10, 1'b1);
        send_byte(8'h00, 1'b1);
        for (int i = 0; i < 16; i++) begin
            w = $urandom;
            exp_adr.push_back({1'b0, AW'(i)});
            exp_dat.push_back(w);
            if (i == 15) exp_resp.push_back(B_ACK);
            send_word(w);
        end
        wait_idle("n16", 20 * BIT);
        check_drained("n16");
        n_checks++;
        if (upg_if.upg_adr_o !== {1'b0, 4'hF}) begin
            n_fail++;
            $display("FAIL n16_last_adr: adr=%h, required 0f", upg_if.upg_adr_o);
        end
    endtask

    task automatic test_timeout();
        int n;
        pulse_start();
        send_byte(8'h49, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        exp_resp.push_back(B_NAK);
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        n = 0;
        while (tx !== 1'b0 && n < (TOB + 4) * BIT) begin
            tick(1);
            n++;
        end
        n_checks++;
        if (n >= (TOB + 4) * BIT || n < (TOB - 2) * BIT) begin
            n_fail++;
            $display("FAIL timeout_delay: %0d cycles, required %0d..%0d",
                     n, (TOB - 2) * BIT, (TOB + 4) * BIT - 1);
        end
        wait_idle("timeout", 20 * BIT);
        check_drained("timeout");
    endtask

    task automatic test_framing();
        pulse_start();
        send_byte(8'h49, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        exp_resp.push_back(B_NAK);
        send_byte(8'hA5, 1'b0);
        wait_idle("ferr", 20 * BIT);
        tick(12 * BIT);
        check_drained("ferr");
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        int lows;
        b = 8'h3C;
        pulse_start();
        send_byte(8'h49, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        exp_adr.push_back('0);
        exp_dat.push_back(32'hCAFE0123);
        send_word(32'hCAFE0123);
        rx = 1'b0;
        tick(BIT);
        for (int i = 0; i < 3; i++) begin
            rx = b[i];
            tick(BIT);
        end
        rst = 1'b0;
        #1;
        check_reset_outputs("reset_mid");
        rx = 1'b1;
        tick(5);
        rst = 1'b1;
        lows = 0;
        for (int i = 0; i < 12 * BIT; i++) begin
            tick(1);
            if (tx !== 1'b1) lows++;
        end
        n_checks++;
        if (lows != 0) begin
            n_fail++;
            $display("FAIL reset_mid_tx: tx low %0d cycles, required 0", lows);
        end
        check_reset_outputs("reset_mid_after");
        check_drained("reset_mid");
    endtask

    initial begin
        test_reset();
        test_rom_image();
        test_dmem_select();
        test_bad_header();
        test_oversize();
        test_timeout();
        test_framing();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_prog_loader.md
# uart_prog_loader

Parametrised UART programmer that replaces the CPU's hard-wired `upg_*` tie-offs. After a `start_pg` request it receives a framed image over `rx` and writes it word by word into the program ROM or data memory through the `upg_*` write port. It reports completion or error on `tx` with an ACK or NAK byte, and holds the CPU in programming mode (`upg_done_o` low) until the transfer ends.

## Interface
Parameters:
- `CLK_HZ`, 23_000_000: frequency of `clk`.
- `BAUD`, 115_200: line rate. The oversampling divisor `DIV = CLK_HZ/(BAUD*16)` is rounded down and must be at least 1.
- `ADDR_W`, 14: word-address width of each memory. `upg_adr_o` is `ADDR_W+1` bits wide; the MSB selects the memory.
- `DATA_W`, 32: word width. Must be a multiple of 8.
- `TIMEOUT_BITS`, 64: idle bit-times allowed between bytes inside a frame.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-low reset.
- `start_pg` in 1: level request to enter programming mode; synchronised internally, rising edge acts.
- `rx` in 1: UART receive line, idle high; two-flop synchronised internally.
- `tx` out 1: UART transmit line, idle high.
- `upg_wen_o` out 1: one-cycle write strobe.
- `upg_adr_o` out ADDR_W+1: bit ADDR_W = 0 selects program ROM, 1 selects data memory; low bits are the word address.
- `upg_dat_o` out DATA_W: write data, valid while `upg_wen_o` is high.
- `upg_done_o` out 1: high means the CPU may run; low means programming is in progress.
- `busy_o` out 1: high in any state other than IDLE.

## Operation
Frame format, all fields little-endian bytes:
- Header byte: 0x49 targets the program ROM, 0x44 targets data memory.
- Count: 2 bytes, N = number of words.
- Payload: N words of DATA_W/8 bytes each.

FSM states: IDLE, HDR, CNT_LO, CNT_HI, DATA, WRITE, RESP, WAIT_TX.
- IDLE: on a `start_pg` rising edge, drop `upg_done_o` and go to HDR.
- HDR: an unknown header byte goes to RESP with NAK.
- CNT_LO, CNT_HI: N = 0 goes to RESP with ACK. N > 2^ADDR_W goes to RESP with NAK, and no writes occur.
- DATA: assemble bytes LSB first. After the last byte of a word, go to WRITE.
- WRITE: pulse `upg_wen_o` for exactly 1 cycle at address `{sel, idx}`, then increment `idx`. Go to RESP with ACK when idx+1 == N, otherwise return to DATA. `idx` starts at 0 and never wraps, because the bound was checked in the count states.
- RESP: load 0x06 (ACK) or 0x15 (NAK) into the transmitter, then go to WAIT_TX.
- WAIT_TX: when the stop bit ends, raise `upg_done_o` and return to IDLE.

Error handling:
- A framing error (stop bit sampled low) in any receive state goes to RESP with NAK.
- In any receive state except HDR, TIMEOUT_BITS bit-times with no start bit goes to RESP with NAK.
- HDR waits indefinitely.
- Words already written before an error stay written.

Simultaneous and unexpected events:
- `start_pg` edges outside IDLE are ignored.
- Bytes that arrive during RESP or WAIT_TX are dropped.

Receiver:
- 16x oversampling. The start bit is validated at the mid-sample (tick 8) and rejected as a glitch if `rx` is high there.
- Data bits and the stop bit are sampled at tick 8 of each bit period.

Transmitter:
- 8N1 format at the same bit period (16 ticks).

## Timing
Reset values (async assert, synchronous deassert not required): state IDLE, `tx`=1, `upg_wen_o`=0, `upg_adr_o`=0, `upg_dat_o`=0, `upg_done_o`=1, `busy_o`=0.

Latencies:
- `busy_o` and `upg_done_o` change 3 cycles after the `start_pg` rising edge: 2 synchroniser cycles plus 1 edge-detect cycle.
- `upg_wen_o` is asserted 2 cycles after the stop-bit sample of a word's last byte.
- Address and data are stable from the `upg_wen_o` cycle until the next write.
- The ACK start bit begins 1 cycle after the final write strobe, or after the error detection.
- `upg_done_o` rises 1 cycle after the response stop bit completes, i.e. 10 bit periods after `tx` falls.
- Sustained throughput is one word per DATA_W/8 byte times. There is no backpressure; memory writes are single-cycle.

Reset mid-operation: any in-flight transfer is aborted with no response byte, and the block restarts from IDLE.

## Structure
- Shared package `cpu_pkg`: header codes `HDR_IMEM`=0x49 and `HDR_DMEM`=0x44, `ACK`=0x06, `NAK`=0x15, and the loader state typedef `upg_state_t`.
- Sub-module `uart_rx`, parametrised by DIV: outputs `byte_o`, `valid_o` (1-cycle pulse), `ferr_o` (framing error) and `tick_o` (bit-period tick for the timeout counter).
- The transmitter, FSM, word assembler and address counter live in the top of this block.

## Test plan
- **ROM image:** start_pg, then bytes 49 02 00 EF BE AD DE 78 56 34 12. Required: two strobes, adr 0x0000 dat 0xDEADBEEF and adr 0x0001 dat 0x12345678; `tx` sends 0x06; `upg_done_o` returns to 1.
- **Data-memory select:** header 0x44 with N=1, payload 01 00 00 00. Required: one strobe at adr 0x4000 (MSB set), dat 0x00000001; ACK.
- **Bad header:** header 0x00. Required: no strobe; `tx` sends 0x15; FSM back in IDLE.
- **Oversized count:** ADDR_W=4 with N=17. Required: NAK and zero writes. N=16 is accepted and the last write lands at adr 0x000F.
- **Timeout:** stop sending after 2 payload bytes. Required: NAK after TIMEOUT_BITS bit-times, no strobe, `upg_done_o`=1.
- **Framing error and reset:** inject stop bit = 0, required: NAK. Separately, assert `rst` mid-payload, required: all outputs return to reset values immediately and `tx` stays 1.
